// File: rtl/uproc_pkg.sv
// Shared types for the 8-bit accumulator microprocessor: opcodes, ALU operations,
// the instruction word layout and default widths.
package uproc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PC_W_DEF   = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_ST   = 4'h7,
    OP_LD   = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_SHL  = 4'hC,
    OP_SHR  = 4'hD,
    OP_ADDI = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5,
    ALU_SHL    = 3'd6,
    ALU_SHR    = 3'd7
  } alu_op_e;

  typedef struct packed {
    opcode_e    op;
    logic [3:0] k;
  } instr_t;

  // Map an opcode onto the ALU operation it needs; non-ALU opcodes pass b through.
  function automatic alu_op_e alu_op_of(input opcode_e op);
    alu_op_e res;
    case (op)
      OP_ADD, OP_ADDI: res = ALU_ADD;
      OP_SUB:          res = ALU_SUB;
      OP_AND:          res = ALU_AND;
      OP_OR:           res = ALU_OR;
      OP_XOR:          res = ALU_XOR;
      OP_SHL:          res = ALU_SHL;
      OP_SHR:          res = ALU_SHR;
      default:         res = ALU_PASS_B;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uproc_alu.sv
// Combinational ALU: arithmetic, logic and single-bit shifts with carry/borrow and zero.
module uproc_alu
  import uproc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           alu_op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] ext_s;

  // Result and carry; SUB reports borrow (a < b) in the extra bit.
  always_comb begin
    ext_s  = {(DATA_W+1){1'b0}};
    result = {DATA_W{1'b0}};
    carry  = 1'b0;
    case (alu_op)
      ALU_PASS_B: result = b;
      ALU_ADD: begin
        ext_s  = {1'b0, a} + {1'b0, b};
        result = ext_s[DATA_W-1:0];
        carry  = ext_s[DATA_W];
      end
      ALU_SUB: begin
        ext_s  = {1'b0, a} - {1'b0, b};
        result = ext_s[DATA_W-1:0];
        carry  = ext_s[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: begin
        result = {DATA_W{1'b0}};
        carry  = 1'b0;
      end
    endcase
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/uproc_core.sv
// Single-cycle 8-bit accumulator microprocessor: PC, ROM, 4-entry register file, flags.
// Optional per-instruction simulation trace when UPROC_TRACE_EN is defined.
module uproc_core
  import uproc_pkg::*;
#(
  parameter int                       DATA_W    = DATA_W_DEF,
  parameter int                       PC_W      = PC_W_DEF,
  parameter string                    ROM_FILE  = "rom.hex",
  parameter logic [8*(2**PC_W)-1:0]   ROM_IMAGE = {(2**PC_W){8'hF0}}
) (
  input  logic              clk,
  input  logic              nReset,
  output logic [PC_W-1:0]   dbg_pc,
  output logic [DATA_W-1:0] dbg_acc,
  output logic [1:0]        dbg_flags,
  output logic              halted
);

  localparam int ROM_D = 2**PC_W;

  logic [7:0]        rom_mem [ROM_D];

  logic [PC_W-1:0]   pc_q,  pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              halted_q, halted_d;

  instr_t            instr_s;
  logic [1:0]        ridx_s;
  logic [DATA_W-1:0] kext_s;
  logic [DATA_W-1:0] alu_b_s;
  logic [DATA_W-1:0] alu_res_s;
  alu_op_e           alu_op_s;
  logic              alu_c_s;
  logic              alu_z_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic [PC_W-1:0]   pc_k_s;

  // ROM contents taken straight from the parameter image.
  always_comb begin
    for (int i = 0; i < ROM_D; i++) rom_mem[i] = ROM_IMAGE[8*i +: 8];
  end

  assign instr_s  = instr_t'(rom_mem[pc_q]);
  assign ridx_s   = instr_s.k[1:0];
  assign kext_s   = {{(DATA_W-4){1'b0}}, instr_s.k};
  assign pc_inc_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc_k_s   = PC_W'(instr_s.k);

  // ALU operand and operation select; immediates feed b for LDI/ADDI.
  always_comb begin
    alu_op_s = alu_op_of(instr_s.op);
    if (instr_s.op == OP_LDI || instr_s.op == OP_ADDI) begin
      alu_b_s = kext_s;
    end else begin
      alu_b_s = rf_q[ridx_s];
    end
  end

  uproc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (acc_q),
    .b      (alu_b_s),
    .alu_op (alu_op_s),
    .result (alu_res_s),
    .carry  (alu_c_s),
    .zero   (alu_z_s)
  );

  // Next-state for one executed instruction; everything holds once halted.
  always_comb begin
    pc_d     = pc_inc_s;
    acc_d    = acc_q;
    rf_d     = rf_q;
    z_d      = z_q;
    c_d      = c_q;
    halted_d = halted_q;
    if (halted_q) begin
      pc_d = pc_q;
    end else begin
      case (instr_s.op)
        OP_NOP: ;
        OP_LDI, OP_LD: begin
          acc_d = alu_res_s;
          z_d   = alu_z_s;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADDI: begin
          acc_d = alu_res_s;
          z_d   = alu_z_s;
          c_d   = alu_c_s;
        end
        OP_ST:  rf_d[ridx_s] = acc_q;
        OP_JMP: pc_d = pc_k_s;
        OP_JZ: begin
          if (z_q) pc_d = pc_k_s;
          else     pc_d = pc_inc_s;
        end
        OP_JC: begin
          if (c_q) pc_d = pc_k_s;
          else     pc_d = pc_inc_s;
        end
        OP_HALT: begin
          halted_d = 1'b1;
          pc_d     = pc_q;
        end
        default: ;
      endcase
    end
  end

  // Architectural state; reset returns to pc=0 with everything cleared.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      pc_q     <= {PC_W{1'b0}};
      acc_q    <= {DATA_W{1'b0}};
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= {DATA_W{1'b0}};
    end else begin
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      c_q      <= c_d;
      halted_q <= halted_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign dbg_pc    = pc_q;
  assign dbg_acc   = acc_q;
  assign dbg_flags = {c_q, z_q};
  assign halted    = halted_q;

`ifdef UPROC_TRACE_EN
  logic [PC_W-1:0] trace_pc;
  instr_t          trace_instr;

  // Capture the executing instruction now, print post-commit state at end of step.
  always @(posedge clk) begin
    if (!nReset && !halted_q) begin
      trace_pc    = pc_q;
      trace_instr = instr_s;
      $strobe("%0t pc=%h op=%h k=%h acc=%h R0=%h R1=%h R2=%h R3=%h C=%b Z=%b",
              $time, trace_pc, trace_instr.op, trace_instr.k, acc_q,
              rf_q[0], rf_q[1], rf_q[2], rf_q[3], c_q, z_q);
    end
  end
`else
`endif

endmodule

// File: tb/tb_uproc_core.sv
// Scoreboard bench: five cores each run a directed ROM program; expectations are queued
// by the stimulus process and checked by a negedge monitor.
module tb_uproc_core;
    import uproc_pkg::*;

    localparam int NDUT      = 5;
    localparam int N_EXP_CMP = 25;

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] acc;
        logic [1:0] fl;
        logic       h;
    } snap_t;

    typedef struct {
        int    dut;
        snap_t exp;
        string name;
    } sb_t;

    typedef struct {
        int    cyc;
        int    dut;
        snap_t exp;
        string name;
    } vec_t;

    logic       clk;
    logic       nReset;
    logic [3:0] pc_w  [NDUT];
    logic [7:0] acc_w [NDUT];
    logic [1:0] fl_w  [NDUT];
    logic       hl_w  [NDUT];

    sb_t  sb_q [$];
    vec_t tbl  [$];
    int   n_cmp;
    int   n_bad;
    bit   done;

    // Program images, word 0 in the low byte; unlisted words read HALT.
    function automatic logic [127:0] prog_img(input int t);
        logic [127:0] r;
        logic [63:0]  p;
        int           n;
        r = {16{8'hF0}};
        case (t)
            0:       begin p = 64'h000000F021137115; n = 5; end
            1:       begin p = 64'h00E2EFC0C0C0C01F; n = 7; end
            2:       begin p = 64'h00F01900F011A510; n = 7; end
            3:       begin p = 64'hF017F0B630117012; n = 8; end
            default: begin p = 64'h000000000091E111; n = 3; end
        endcase
        for (int i = 0; i < n; i++) r[8*i +: 8] = p[8*i +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uproc_core #(
            .DATA_W    (8),
            .PC_W      (4),
            .ROM_FILE  (""),
            .ROM_IMAGE (prog_img(g))
        ) dut (
            .clk       (clk),
            .nReset    (nReset),
            .dbg_pc    (pc_w[g]),
            .dbg_acc   (acc_w[g]),
            .dbg_flags (fl_w[g]),
            .halted    (hl_w[g])
        );
    end

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input int d, input logic [3:0] pc, input logic [7:0] acc,
                            input logic [1:0] fl, input logic h, input string name);
        sb_t e;
        e.dut  = d;
        e.exp  = {pc, acc, fl, h};
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic add_vec(input int cyc, input int d, input logic [3:0] pc,
                           input logic [7:0] acc, input logic [1:0] fl, input logic h,
                           input string name);
        vec_t v;
        v.cyc  = cyc;
        v.dut  = d;
        v.exp  = {pc, acc, fl, h};
        v.name = name;
        tbl.push_back(v);
    endtask

    // Watchdog: fail if the stimulus never completes.
    initial begin
        done = 1'b0;
        #100000;
        if (!done) begin
            $display("FAIL timeout: stimulus did not complete");
            $finish;
        end else begin
        end
    end

    // Monitor: every expectation queued since the last edge is compared here.
    initial begin
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                sb_t   e;
                snap_t act;
                e   = sb_q.pop_front();
                act = {pc_w[e.dut], acc_w[e.dut], fl_w[e.dut], hl_w[e.dut]};
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s dut%0d: got pc=%h acc=%h CZ=%b halted=%b, want pc=%h acc=%h CZ=%b halted=%b",
                             e.name, e.dut, act.pc, act.acc, act.fl, act.h,
                             e.exp.pc, e.exp.acc, e.exp.fl, e.exp.h);
                end
            end
        end
    end

    // Stimulus: reset, run all programs together, then a mid-run asynchronous reset.
    initial begin
        add_vec(1, 0, 4'h1, 8'h05, 2'b00, 1'b0, "first_edge_pc1");
        add_vec(5, 0, 4'h4, 8'h08, 2'b00, 1'b1, "add_halt");
        add_vec(9, 0, 4'h4, 8'h08, 2'b00, 1'b1, "halt_frozen");
        add_vec(5, 1, 4'h5, 8'hF0, 2'b00, 1'b0, "shl_x4");
        add_vec(6, 1, 4'h6, 8'hFF, 2'b00, 1'b0, "addi15");
        add_vec(7, 1, 4'h7, 8'h01, 2'b10, 1'b0, "addi2_carry");
        add_vec(8, 1, 4'h7, 8'h01, 2'b10, 1'b1, "shl_prog_halt");
        add_vec(1, 2, 4'h1, 8'h00, 2'b01, 1'b0, "ldi0_zero");
        add_vec(2, 2, 4'h5, 8'h00, 2'b01, 1'b0, "jz_taken");
        add_vec(4, 2, 4'h6, 8'h09, 2'b00, 1'b1, "jz_prog_halt");
        add_vec(9, 2, 4'h6, 8'h09, 2'b00, 1'b1, "jz_prog_frozen");
        add_vec(4, 3, 4'h4, 8'hFF, 2'b10, 1'b0, "sub_borrow");
        add_vec(5, 3, 4'h6, 8'hFF, 2'b10, 1'b0, "jc_taken");
        add_vec(7, 3, 4'h7, 8'h07, 2'b10, 1'b1, "jc_prog_halt");
        add_vec(6, 4, 4'h2, 8'h04, 2'b00, 1'b0, "loop_run");

        nReset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            if (pc_w[d] !== 4'h0 || acc_w[d] !== 8'h00 || fl_w[d] !== 2'b00 || hl_w[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_direct dut%0d: pc=%h acc=%h CZ=%b halted=%b",
                         d, pc_w[d], acc_w[d], fl_w[d], hl_w[d]);
            end
        end
        for (int d = 0; d < NDUT; d++) push_exp(d, 4'h0, 8'h00, 2'b00, 1'b0, "reset_state");
        @(negedge clk);
        #1 nReset = 1'b0;

        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            foreach (tbl[i]) begin
                if (tbl[i].cyc == c) begin
                    sb_t e;
                    e.dut  = tbl[i].dut;
                    e.exp  = tbl[i].exp;
                    e.name = tbl[i].name;
                    sb_q.push_back(e);
                end
            end
        end

        @(posedge clk);
        #3 nReset = 1'b1;
        push_exp(4, 4'h0, 8'h00, 2'b00, 1'b0, "async_reset_loop");
        push_exp(0, 4'h0, 8'h00, 2'b00, 1'b0, "async_reset_halted");
        @(negedge clk);
        #1 nReset = 1'b0;
        @(posedge clk);
        #1;
        push_exp(4, 4'h1, 8'h01, 2'b00, 1'b0, "restart_pc1");
        push_exp(0, 4'h1, 8'h05, 2'b00, 1'b0, "restart_after_halt");
        @(posedge clk);
        #1;
        push_exp(4, 4'h2, 8'h02, 2'b00, 1'b0, "restart_pc2");

        repeat (2) @(negedge clk);
        #1;
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        if (n_bad != 0 || n_cmp != N_EXP_CMP) begin
            $display("FAIL: %0d mismatches, %0d of %0d comparisons executed", n_bad, n_cmp, N_EXP_CMP);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule
